// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the pipelined RISC-V core. It takes the M-stage control
// and data from the Execute/Memory register and drives a valid/grant data-memory
// port. It stalls the front of the pipeline while a load or store is
// outstanding. It also holds the Memory/Writeback register with the selected
// write-back result.
//
// Parameters
//   MAX_WAIT   cycles an op may stay outstanding before it is forced to
//              complete (1..255)
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   RegWriteM, MemWriteM, LUIInstrM  M-stage control
//   ResultSrcM[1:0]                  00 ALU, 01 load, 10 PC+4, 11 ExtImm
//   RdM[4:0]                         destination register
//   ALUResultM, WriteDataM,
//   ExtImmM, PCPlus4M [31:0]         M-stage data
//   memReq, memWe, memAddr, memWData request side of the data-memory port
//   memGnt, memRValid, memRData      response side of the data-memory port
//   StallM                           freezes PC, F/D, D/E and E/M registers
//   ForwardM[31:0]                   M-stage forwarding value for the hazard unit
//   RegWriteW, RdW, ResultW          Memory/Writeback register
//   memTimeout                       sticky: some op ran into MAX_WAIT
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        LUIInstrM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ExtImmM,
  input  logic [31:0] PCPlus4M,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memGnt,
  input  logic        memRValid,
  input  logic [31:0] memRData,
  output logic        StallM,
  output logic [31:0] ForwardM,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW,
  output logic        memTimeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [1:0]  r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_timeout;
  logic        r_regwrite_w;
  logic [4:0]  r_rd_w;
  logic [31:0] r_result_w;

  logic [1:0]  w_state_nxt;
  logic        w_mem_op;
  logic        w_req;
  logic        w_real_done;
  logic        w_timeout;
  logic        w_done;
  logic        w_stall;
  logic [31:0] w_result;

  // A store wins over a load if both encodings appear together.
  assign w_mem_op = MemWriteM | (ResultSrcM == 2'b01);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_real_done = 1'b0;
    case (r_state)
      S_IDLE, S_REQ: begin
        w_req = (r_state == S_REQ) | w_mem_op;
        if (w_mem_op) begin
          if (memGnt && (MemWriteM || memRValid)) begin
            w_real_done = 1'b1;
          end else if (memGnt) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_WAIT: begin
        w_real_done = memRValid;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // The counter holds the number of cycles the op has already been
    // outstanding, so the stall lasts exactly MAX_WAIT cycles before the
    // forced completion. A genuine completion in that same cycle wins.
    w_timeout = (r_state != S_IDLE) && !w_real_done && (r_wait_cnt == MAX_WAIT_C);
    w_done    = w_real_done | w_timeout;
    if (w_done) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign w_stall = w_mem_op & ~w_done;

  always_comb begin
    w_result = ALUResultM;
    if (LUIInstrM) begin
      w_result = ExtImmM;
    end else begin
      case (ResultSrcM)
        2'b00:   w_result = ALUResultM;
        2'b01:   w_result = w_timeout ? 32'd0 : memRData;
        2'b10:   w_result = PCPlus4M;
        default: w_result = ExtImmM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (w_state_nxt == S_IDLE) ? 8'd0 : r_wait_cnt + 8'd1;
      r_timeout  <= r_timeout | w_timeout;
    end
  end

  // Memory/Writeback register: a stalled instruction leaves a bubble behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite_w <= 1'b0;
      r_rd_w       <= 5'd0;
      r_result_w   <= 32'd0;
    end else if (w_stall) begin
      r_regwrite_w <= 1'b0;
      r_rd_w       <= 5'd0;
      r_result_w   <= 32'd0;
    end else begin
      r_regwrite_w <= RegWriteM & (RdM != 5'd0);
      r_rd_w       <= RdM;
      r_result_w   <= w_result;
    end
  end

  assign memReq     = w_req;
  assign memWe      = w_req & MemWriteM;
  assign memAddr    = ALUResultM;
  assign memWData   = WriteDataM;
  assign StallM     = w_stall;
  assign ForwardM   = LUIInstrM ? ExtImmM : ALUResultM;
  assign memTimeout = r_timeout | w_timeout;
  assign RegWriteW  = r_regwrite_w;
  assign RdW        = r_rd_w;
  assign ResultW    = r_result_w;

endmodule
